// File: rtl/spi_mem_arbiter.sv
// ============================================================================
//  Module   : spi_mem_arbiter
//  Brief    : Round-robin share of one SPI master between the fetch (ROM) and
//             data (RAM) ports, one transaction in flight, with hang timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              spi_start,
  output logic              spi_write,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [DATA_W-1:0] spi_wdata,
  output logic              sel_ram,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rdata,
  output logic              timeout_err
);

  localparam int                 c_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
  localparam bit                 c_TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state,   w_state;
  logic                r_last_d,  w_last_d;
  logic [c_CNT_W-1:0]  r_cnt,     w_cnt;
  logic                r_f_gnt,   w_f_gnt;
  logic                r_d_gnt,   w_d_gnt;
  logic                r_f_valid, w_f_valid;
  logic                r_d_valid, w_d_valid;
  logic [DATA_W-1:0]   r_f_rdata, w_f_rdata;
  logic [DATA_W-1:0]   r_d_rdata, w_d_rdata;
  logic                r_start,   w_start;
  logic                r_write,   w_write;
  logic [ADDR_W-1:0]   r_addr,    w_addr;
  logic [DATA_W-1:0]   r_wdata,   w_wdata;
  logic                r_sel_ram, w_sel_ram;
  logic                r_to_err,  w_to_err;

  logic                w_pick_d;
  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic                w_expired;

  // On a tie the port that did not win last time takes the grant.
  assign w_pick_d  = d_req && (!f_req || !r_last_d);
  assign w_cnt_inc = r_cnt + c_CNT_W'(1);
  assign w_expired = c_TO_EN && (w_cnt_inc == c_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b1;
      r_cnt     <= '0;
      r_f_gnt   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_f_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
      r_start   <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel_ram <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_last_d  <= w_last_d;
      r_cnt     <= w_cnt;
      r_f_gnt   <= w_f_gnt;
      r_d_gnt   <= w_d_gnt;
      r_f_valid <= w_f_valid;
      r_d_valid <= w_d_valid;
      r_f_rdata <= w_f_rdata;
      r_d_rdata <= w_d_rdata;
      r_start   <= w_start;
      r_write   <= w_write;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_sel_ram <= w_sel_ram;
      r_to_err  <= w_to_err;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_last_d  = r_last_d;
    w_cnt     = r_cnt;
    w_f_gnt   = 1'b0;
    w_d_gnt   = 1'b0;
    w_f_valid = 1'b0;
    w_d_valid = 1'b0;
    w_f_rdata = r_f_rdata;
    w_d_rdata = r_d_rdata;
    w_start   = 1'b0;
    w_write   = r_write;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_sel_ram = r_sel_ram;
    w_to_err  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (f_req || d_req) begin
          w_state   = S_BUSY;
          w_start   = 1'b1;
          w_cnt     = '0;
          w_last_d  = w_pick_d;
          w_sel_ram = w_pick_d;
          if (w_pick_d) begin
            w_d_gnt = 1'b1;
            w_write = d_we;
            w_addr  = d_addr;
            w_wdata = d_wdata;
          end else begin
            w_f_gnt = 1'b1;
            w_write = 1'b0;
            w_addr  = f_addr;
            w_wdata = '0;
          end
        end
      end

      S_BUSY: begin
        w_start = 1'b1;
        w_cnt   = w_cnt_inc;
        // A done arriving on the expiry cycle still counts as a clean finish.
        if (spi_done || w_expired) begin
          w_state  = S_RESP;
          w_start  = 1'b0;
          w_to_err = !spi_done;
          if (r_sel_ram) begin
            w_d_valid = 1'b1;
            if (!r_write) w_d_rdata = spi_done ? spi_rdata : {DATA_W{1'b1}};
          end else begin
            w_f_valid = 1'b1;
            w_f_rdata = spi_done ? spi_rdata : {DATA_W{1'b1}};
          end
        end
      end

      S_RESP: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign f_gnt       = r_f_gnt;
  assign d_gnt       = r_d_gnt;
  assign f_valid     = r_f_valid;
  assign d_valid     = r_d_valid;
  assign f_rdata     = r_f_rdata;
  assign d_rdata     = r_d_rdata;
  assign spi_start   = r_start;
  assign spi_write   = r_write;
  assign spi_addr    = r_addr;
  assign spi_wdata   = r_wdata;
  assign sel_ram     = r_sel_ram;
  assign timeout_err = r_to_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_mem_arbiter.sv
// ============================================================================
//  Module   : tb_spi_mem_arbiter
//  Brief    : Directed self-checking bench for spi_mem_arbiter (TIMEOUT = 8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_mem_arbiter;

  localparam int c_ADDR_W  = 16;
  localparam int c_DATA_W  = 8;
  localparam int c_TIMEOUT = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                f_req, d_req, d_we, spi_done;
  logic [c_ADDR_W-1:0] f_addr, d_addr;
  logic [c_DATA_W-1:0] d_wdata, spi_rdata;
  logic                f_gnt, f_valid, d_gnt, d_valid;
  logic [c_DATA_W-1:0] f_rdata, d_rdata, spi_wdata;
  logic                spi_start, spi_write, sel_ram, timeout_err;
  logic [c_ADDR_W-1:0] spi_addr;

  int n_checks = 0;
  int n_errors = 0;

  spi_mem_arbiter #(
    .ADDR_W (c_ADDR_W),
    .DATA_W (c_DATA_W),
    .TIMEOUT(c_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_gnt      (f_gnt),
    .f_valid    (f_valid),
    .f_rdata    (f_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_valid    (d_valid),
    .d_rdata    (d_rdata),
    .spi_start  (spi_start),
    .spi_write  (spi_write),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .sel_ram    (sel_ram),
    .spi_done   (spi_done),
    .spi_rdata  (spi_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold BUSY for n_busy cycles, then present done with the given read data.
  task automatic finish_xfer(input int n_busy, input logic [c_DATA_W-1:0] rd);
    repeat (n_busy) tick();
    spi_done  = 1'b1;
    spi_rdata = rd;
    tick();
    spi_done  = 1'b0;
  endtask

  initial begin
    int n_start;
    bit seen;

    rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; spi_done = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; spi_rdata = '0;
    #2;
    chk("rst_start", spi_start, 0);
    chk("rst_gnt",   {f_gnt, d_gnt}, 0);
    chk("rst_valid", {f_valid, d_valid, timeout_err}, 0);
    chk("rst_data",  {spi_addr, f_rdata, d_rdata, sel_ram}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fetch read
    f_req = 1'b1; f_addr = 16'h0012;
    tick();
    f_req = 1'b0;
    chk("t1_gnt",   {f_gnt, d_gnt}, 2'b10);
    chk("t1_start", spi_start, 1);
    chk("t1_sel",   sel_ram, 0);
    chk("t1_addr",  spi_addr, 16'h0012);
    finish_xfer(4, 8'hA5);
    chk("t1_valid", {f_valid, d_valid, timeout_err}, 3'b100);
    chk("t1_rdata", f_rdata, 8'hA5);
    chk("t1_resp",  {spi_start, sel_ram, spi_addr}, {2'b00, 16'h0012});
    tick();

    // Data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 8'h3C;
    tick();
    d_req = 1'b0;
    chk("t2_gnt",  {f_gnt, d_gnt}, 2'b01);
    chk("t2_ctrl", {spi_write, sel_ram, spi_wdata, spi_addr}, {2'b11, 8'h3C, 16'h0040});
    finish_xfer(2, 8'h77);
    chk("t2_valid", {f_valid, d_valid}, 2'b01);
    chk("t2_rdata", d_rdata, 8'h00);
    tick();

    // Both requesting: F,D,F,D
    f_req = 1'b1; f_addr = 16'h0100; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_gnt", {f_gnt, d_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      finish_xfer(0, 8'(8'h10 + i));
      chk("t3_resp_gnt", {f_gnt, d_gnt}, 2'b00);
      chk("t3_rdata", (i % 2 == 0) ? f_rdata : d_rdata, 8'(8'h10 + i));
      tick();
      chk("t3_idle_gnt", {f_gnt, d_gnt, spi_start}, 3'b000);
    end
    f_req = 1'b0; d_req = 1'b0;

    // Timeout on a data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0055;
    tick();
    d_req = 1'b0;
    chk("t4_gnt", d_gnt, 1);
    n_start = spi_start ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (timeout_err) seen = 1'b1;
      else if (spi_start) n_start++;
    end
    chk("t4_seen",   seen, 1);
    chk("t4_cycles", n_start, c_TIMEOUT);
    chk("t4_valid",  {d_valid, spi_start}, 2'b10);
    chk("t4_rdata",  d_rdata, 8'hFF);
    tick();
    f_req = 1'b1; f_addr = 16'h0033;
    tick();
    f_req = 1'b0;
    chk("t4_next_gnt", f_gnt, 1);
    finish_xfer(3, 8'h5A);
    chk("t4_next", {f_valid, timeout_err, f_rdata}, {2'b10, 8'h5A});
    tick();

    // Reset while BUSY
    d_req = 1'b1; d_addr = 16'h0066;
    tick();
    chk("t5_gnt", d_gnt, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst", {spi_start, f_gnt, d_gnt, f_valid, d_valid}, 5'b0);
    f_req = 1'b1; f_addr = 16'h0088;
    #3;
    rst_n = 1'b1;
    tick();
    chk("t5_tie", {f_gnt, d_gnt}, 2'b10);
    f_req = 1'b0; d_req = 1'b0;
    finish_xfer(2, 8'h11);
    chk("t5_done", {f_valid, f_rdata}, {1'b1, 8'h11});
    tick();

    // Stray done in IDLE, then req dropped mid-BUSY
    spi_done = 1'b1; spi_rdata = 8'hEE;
    tick();
    spi_done = 1'b0;
    chk("t6_stray", {f_valid, d_valid, spi_start, timeout_err}, 4'b0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0077;
    tick();
    chk("t6_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    finish_xfer(2, 8'h3E);
    chk("t6_valid", {d_valid, d_rdata}, {1'b1, 8'h3E});
    chk("t6_frd",   f_rdata, 8'h11);
    tick();
    chk("t6_idle",  {d_valid, spi_start}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
